id_stage: RTL and testbench

- RV32I instruction decode stage. Sits between the fetch stage and execute.
- Consumes the IF/ID pipeline register (pc, inst, valid) and decodes the instruction.
- Owns the 32x32 integer register file, with read in ID and write from writeback.
- Detects load-use hazards, stalls fetch, and produces the ID/EX pipeline register.

---
 rtl/id_stage.sv | 199 +++++++++++++++++++
 tb/tb_id_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID decode, 32x32 register file, load-use stall, ID/EX register.
// Ports: clk, rst (async, high), en, next_rdy, flush, if_id {pc,inst,valid}, wb_en/wb_rd/wb_data,
//        id_ex {pc,rs1_val,rs2_val,imm,rs1,rs2,rd,opcode,funct3,funct7,
//               is_load,is_store,is_branch,is_jump,wr_en,illegal,valid}, rdy.
module id_stage #(
    parameter int REG_COUNT = 32,
    parameter int XLEN      = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         next_rdy,
    input  logic         flush,
    input  logic [64:0]  if_id,
    input  logic         wb_en,
    input  logic [4:0]   wb_rd,
    input  logic [31:0]  wb_data,
    output logic [166:0] id_ex,
    output logic         rdy
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [XLEN-1:0] w_pc;
    logic [31:0]     w_inst;
    logic            w_valid;
    logic [6:0]      w_opcode;
    logic [4:0]      w_rd, w_rs1, w_rs2;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;

    assign w_pc     = if_id[64:33];
    assign w_inst   = if_id[32:1];
    assign w_valid  = if_id[0];
    assign w_opcode = w_inst[6:0];
    assign w_rd     = w_inst[11:7];
    assign w_funct3 = w_inst[14:12];
    assign w_rs1    = w_inst[19:15];
    assign w_rs2    = w_inst[24:20];
    assign w_funct7 = w_inst[31:25];

    logic [XLEN-1:0] w_imm;
    logic w_legal, w_wr_op, w_uses_rs1, w_uses_rs2;
    logic w_load, w_store, w_branch, w_jump;

    always_comb begin
        w_imm      = '0;
        w_legal    = 1'b1;
        w_wr_op    = 1'b0;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b0;
        w_load     = 1'b0;
        w_store    = 1'b0;
        w_branch   = 1'b0;
        w_jump     = 1'b0;
        case (w_opcode)
            OP_LUI, OP_AUIPC: begin
                w_imm      = {w_inst[31:12], 12'b0};
                w_wr_op    = 1'b1;
                w_uses_rs1 = 1'b0;
            end
            OP_JAL: begin
                w_imm      = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12],
                              w_inst[20], w_inst[30:21], 1'b0};
                w_wr_op    = 1'b1;
                w_uses_rs1 = 1'b0;
                w_jump     = 1'b1;
            end
            OP_JALR: begin
                w_imm   = {{20{w_inst[31]}}, w_inst[31:20]};
                w_wr_op = 1'b1;
                w_jump  = 1'b1;
            end
            OP_BRANCH: begin
                w_imm      = {{19{w_inst[31]}}, w_inst[31], w_inst[7],
                              w_inst[30:25], w_inst[11:8], 1'b0};
                w_uses_rs2 = 1'b1;
                w_branch   = 1'b1;
            end
            OP_LOAD: begin
                w_imm   = {{20{w_inst[31]}}, w_inst[31:20]};
                w_wr_op = 1'b1;
                w_load  = 1'b1;
            end
            OP_STORE: begin
                w_imm      = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
                w_uses_rs2 = 1'b1;
                w_store    = 1'b1;
            end
            OP_IMM: begin
                w_imm   = {{20{w_inst[31]}}, w_inst[31:20]};
                w_wr_op = 1'b1;
            end
            OP_OP: begin
                w_wr_op    = 1'b1;
                w_uses_rs2 = 1'b1;
            end
            OP_FENCE, OP_SYSTEM: ;
            default: w_legal = 1'b0;
        endcase
    end

    logic w_illegal;
    assign w_illegal = !w_legal || (w_inst[1:0] != 2'b11);

    // Register file; x0 is not stored.
    logic [XLEN-1:0] r_regs [1:REG_COUNT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < REG_COUNT; i++) r_regs[i] <= '0;
        end else if (wb_en && wb_rd != 5'd0) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    // Same-cycle writeback is forwarded so decode never sees a stale value.
    logic [XLEN-1:0] w_rs1_val, w_rs2_val;

    always_comb begin
        w_rs1_val = '0;
        w_rs2_val = '0;
        if (w_rs1 != 5'd0)
            w_rs1_val = (wb_en && wb_rd == w_rs1) ? wb_data : r_regs[w_rs1];
        if (w_rs2 != 5'd0)
            w_rs2_val = (wb_en && wb_rd == w_rs2) ? wb_data : r_regs[w_rs2];
    end

    logic [XLEN-1:0] r_pc, r_rs1_val, r_rs2_val, r_imm;
    logic [4:0]      r_rs1, r_rs2, r_rd;
    logic [6:0]      r_opcode, r_funct7;
    logic [2:0]      r_funct3;
    logic r_load, r_store, r_branch, r_jump, r_wr_en, r_illegal, r_valid;

    logic w_hazard;
    assign w_hazard = r_valid && r_load && (r_rd != 5'd0) &&
                      ((w_uses_rs1 && w_rs1 == r_rd) ||
                       (w_uses_rs2 && w_rs2 == r_rd));

    assign rdy = en && next_rdy && !w_hazard && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= '0;
            r_rs1_val <= '0;
            r_rs2_val <= '0;
            r_imm     <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_opcode  <= '0;
            r_funct3  <= '0;
            r_funct7  <= '0;
            r_load    <= 1'b0;
            r_store   <= 1'b0;
            r_branch  <= 1'b0;
            r_jump    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_illegal <= 1'b0;
            r_valid   <= 1'b0;
        end else if (next_rdy) begin
            if (flush || w_hazard) begin
                // Squash or bubble: payload fields are held.
                r_valid <= 1'b0;
            end else begin
                r_pc      <= w_pc;
                r_rs1_val <= w_rs1_val;
                r_rs2_val <= w_rs2_val;
                r_imm     <= w_imm;
                r_rs1     <= w_rs1;
                r_rs2     <= w_rs2;
                r_rd      <= w_rd;
                r_opcode  <= w_opcode;
                r_funct3  <= w_funct3;
                r_funct7  <= w_funct7;
                r_load    <= !w_illegal && w_load;
                r_store   <= !w_illegal && w_store;
                r_branch  <= !w_illegal && w_branch;
                r_jump    <= !w_illegal && w_jump;
                r_wr_en   <= !w_illegal && w_wr_op && (w_rd != 5'd0);
                r_illegal <= w_illegal;
                r_valid   <= en && w_valid;
            end
        end
    end

    assign id_ex = {r_pc, r_rs1_val, r_rs2_val, r_imm, r_rs1, r_rs2, r_rd,
                    r_opcode, r_funct3, r_funct7, r_load, r_store, r_branch,
                    r_jump, r_wr_en, r_illegal, r_valid};
endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage.
// Drives fetch/writeback inputs and checks ID/EX fields against hand-computed values.
module tb_id_stage;
    logic         clk = 1'b0;
    logic         rst, en, next_rdy, flush, wb_en, rdy;
    logic [64:0]  if_id;
    logic [4:0]   wb_rd;
    logic [31:0]  wb_data;
    logic [166:0] id_ex;

    int n_checks = 0;
    int n_errors = 0;

    localparam int F_VALID = 0;
    localparam int F_ILL   = 1;
    localparam int F_WREN  = 2;
    localparam int F_JUMP  = 3;
    localparam int F_BR    = 4;
    localparam int F_ST    = 5;
    localparam int F_LD    = 6;
    localparam int F_RD    = 24;
    localparam int F_IMM   = 39;
    localparam int F_RS2V  = 71;
    localparam int F_RS1V  = 103;
    localparam int F_PC    = 135;

    id_stage dut (
        .clk(clk), .rst(rst), .en(en), .next_rdy(next_rdy), .flush(flush),
        .if_id(if_id), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_ex(id_ex), .rdy(rdy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fld(input int lsb, input int w);
        logic [166:0] s;
        s = id_ex >> lsb;
        return s[31:0] & ((w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 1));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic feed(input logic [31:0] pc, input logic [31:0] inst);
        if_id = {pc, inst, 1'b1};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; next_rdy = 1'b1; flush = 1'b0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0; if_id = '0;
        #1;
        check("rst_valid", fld(F_VALID, 1), 0);
        check("rst_pc", fld(F_PC, 32), 0);
        check("rst_imm", fld(F_IMM, 32), 0);
        check("rst_rdy", {31'b0, rdy}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // addi x1,x0,5
        feed(32'h100, 32'h00500093);
        #1 check("addi_rdy", {31'b0, rdy}, 1);
        tick();
        check("addi_rd", fld(F_RD, 5), 1);
        check("addi_imm", fld(F_IMM, 32), 5);
        check("addi_rs1v", fld(F_RS1V, 32), 0);
        check("addi_wren", fld(F_WREN, 1), 1);
        check("addi_valid", fld(F_VALID, 1), 1);
        check("addi_pc", fld(F_PC, 32), 32'h100);

        // add x3,x2,x1 with writeback of x1=7 in the same cycle
        feed(32'h104, 32'h001101B3);
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd7;
        tick();
        wb_en = 1'b0;
        check("byp_rs2v", fld(F_RS2V, 32), 7);
        check("byp_rd", fld(F_RD, 5), 3);
        check("byp_imm", fld(F_IMM, 32), 0);

        // addi x4,x1,0 reads stored x1
        feed(32'h108, 32'h00008213);
        tick();
        check("rf_x1", fld(F_RS1V, 32), 7);

        // load-use: lw x2,0(x1) then add x3,x2,x1
        feed(32'h200, 32'h0000A103);
        tick();
        check("lw_isload", fld(F_LD, 1), 1);
        feed(32'h204, 32'h001101B3);
        #1 check("lu_rdy0", {31'b0, rdy}, 0);
        tick();
        check("lu_bubble", fld(F_VALID, 1), 0);
        check("lu_rdy1", {31'b0, rdy}, 1);
        tick();
        check("lu_valid", fld(F_VALID, 1), 1);
        check("lu_pc", fld(F_PC, 32), 32'h204);

        // beq x0,x0,-4
        feed(32'h300, 32'hFE000EE3);
        tick();
        check("br_imm", fld(F_IMM, 32), 32'hFFFF_FFFC);
        check("br_isbr", fld(F_BR, 1), 1);
        check("br_wren", fld(F_WREN, 1), 0);
        check("br_valid", fld(F_VALID, 1), 1);
        flush = 1'b1;
        tick();
        check("flush_valid", fld(F_VALID, 1), 0);
        flush = 1'b0;

        // flush together with a load-use hazard
        feed(32'h310, 32'h0000A103);
        tick();
        feed(32'h314, 32'h001101B3);
        flush = 1'b1;
        #1 check("fh_rdy", {31'b0, rdy}, 0);
        tick();
        check("fh_valid", fld(F_VALID, 1), 0);
        flush = 1'b0;

        // backpressure
        feed(32'h400, 32'h00500093);
        tick();
        check("bp_pc0", fld(F_PC, 32), 32'h400);
        feed(32'h404, 32'h00008213);
        next_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_rdy", {31'b0, rdy}, 0);
            tick();
            check("bp_hold_pc", fld(F_PC, 32), 32'h400);
            check("bp_hold_v", fld(F_VALID, 1), 1);
        end
        next_rdy = 1'b1;
        #1 check("bp_rel_rdy", {31'b0, rdy}, 1);
        tick();
        check("bp_rel_pc", fld(F_PC, 32), 32'h404);
        check("bp_rel_rd", fld(F_RD, 5), 4);

        // illegal encodings
        feed(32'h500, 32'hFFFFFFFF);
        tick();
        check("ill_flag", fld(F_ILL, 1), 1);
        check("ill_wren", fld(F_WREN, 1), 0);
        check("ill_jump", fld(F_JUMP, 1), 0);
        check("ill_valid", fld(F_VALID, 1), 1);
        feed(32'h504, 32'h00500091);
        tick();
        check("ill_low2", fld(F_ILL, 1), 1);
        check("ill_low2_wr", fld(F_WREN, 1), 0);

        // write to x0 is ignored, including bypass
        feed(32'h600, 32'h00000293);
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
        tick();
        check("x0_byp", fld(F_RS1V, 32), 0);
        tick();
        wb_en = 1'b0;
        check("x0_read", fld(F_RS1V, 32), 0);

        // en=0
        en = 1'b0;
        feed(32'h700, 32'h00500093);
        #1 check("en0_rdy", {31'b0, rdy}, 0);
        tick();
        check("en0_valid", fld(F_VALID, 1), 0);
        en = 1'b1;

        // async reset mid-stream discards x5
        feed(32'h800, 32'h00500093);
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
        tick();
        wb_en = 1'b0;
        feed(32'h804, 32'h00028313);
        tick();
        check("pre_x5", fld(F_RS1V, 32), 32'h1234);
        check("pre_valid", fld(F_VALID, 1), 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", fld(F_VALID, 1), 0);
        check("mid_rst_rdy", {31'b0, rdy}, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_x5", fld(F_RS1V, 32), 0);
        check("post_valid", fld(F_VALID, 1), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
